// File: rtl/adder_bist_ctrl.sv
// rtl/adder_bist_ctrl.sv - exhaustive operand sweep and result checker for a registered adder
module adder_bist_ctrl #(
    parameter int WIDTH = 4,
    parameter int LAT   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH:0]     result,
    output logic [WIDTH-1:0]   op_a,
    output logic [WIDTH-1:0]   op_b,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b,
    output logic [WIDTH:0]     fail_res
);

    localparam int VW = 2 * WIDTH;
    localparam logic [VW-1:0] VEC_LAST   = '1;
    localparam logic [2:0]    DRAIN_LAST = 3'(LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [VW-1:0]    vec_q, vec_d;
    logic [2:0]       drain_q, drain_d;
    logic [VW:0]      err_q, err_d;
    logic             ff_q, ff_d;
    logic             pass_q, pass_d;
    logic [WIDTH-1:0] fail_a_q, fail_a_d;
    logic [WIDTH-1:0] fail_b_q, fail_b_d;
    logic [WIDTH:0]   fail_res_q, fail_res_d;

    // Expected-value pipeline; stage LAT-1 lines up with the adder's result.
    logic [LAT-1:0]              pv_q, pv_d;
    logic [LAT-1:0][WIDTH-1:0]   pa_q, pa_d;
    logic [LAT-1:0][WIDTH-1:0]   pb_q, pb_d;
    logic [LAT-1:0][WIDTH:0]     pe_q, pe_d;

    logic mism;
    logic start_sweep;

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        drain_d     = drain_q;
        err_d       = err_q;
        ff_d        = ff_q;
        pass_d      = pass_q;
        fail_a_d    = fail_a_q;
        fail_b_d    = fail_b_q;
        fail_res_d  = fail_res_q;
        start_sweep = 1'b0;

        for (int i = 1; i < LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pa_d[i] = pa_q[i-1];
            pb_d[i] = pb_q[i-1];
            pe_d[i] = pe_q[i-1];
        end
        pv_d[0] = (state_q == S_RUN);
        pa_d[0] = vec_q[VW-1:WIDTH];
        pb_d[0] = vec_q[WIDTH-1:0];
        pe_d[0] = {1'b0, vec_q[VW-1:WIDTH]} + {1'b0, vec_q[WIDTH-1:0]};

        mism = pv_q[LAT-1] && (result != pe_q[LAT-1]);
        if (mism) begin
            err_d = err_q + 1'b1;
            if (!ff_q) begin
                ff_d       = 1'b1;
                fail_a_d   = pa_q[LAT-1];
                fail_b_d   = pb_q[LAT-1];
                fail_res_d = result;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) start_sweep = 1'b1;
            end
            S_RUN: begin
                if (vec_q == VEC_LAST) begin
                    state_d = S_DRAIN;
                    drain_d = 3'd0;
                end else begin
                    vec_d = vec_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                    // err_d already includes a mismatch seen on this same edge
                    pass_d  = (err_d == '0);
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_DONE: begin
                if (start) start_sweep = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (start_sweep) begin
            state_d    = S_RUN;
            vec_d      = '0;
            err_d      = '0;
            ff_d       = 1'b0;
            pass_d     = 1'b0;
            fail_a_d   = '0;
            fail_b_d   = '0;
            fail_res_d = '0;
            pv_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            vec_q      <= '0;
            drain_q    <= '0;
            err_q      <= '0;
            ff_q       <= 1'b0;
            pass_q     <= 1'b0;
            fail_a_q   <= '0;
            fail_b_q   <= '0;
            fail_res_q <= '0;
            pv_q       <= '0;
            pa_q       <= '0;
            pb_q       <= '0;
            pe_q       <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            drain_q    <= drain_d;
            err_q      <= err_d;
            ff_q       <= ff_d;
            pass_q     <= pass_d;
            fail_a_q   <= fail_a_d;
            fail_b_q   <= fail_b_d;
            fail_res_q <= fail_res_d;
            pv_q       <= pv_d;
            pa_q       <= pa_d;
            pb_q       <= pb_d;
            pe_q       <= pe_d;
        end
    end

    assign op_a      = vec_q[VW-1:WIDTH];
    assign op_b      = vec_q[WIDTH-1:0];
    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_a    = fail_a_q;
    assign fail_b    = fail_b_q;
    assign fail_res  = fail_res_q;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// tb/tb_adder_bist_ctrl.sv - directed and randomized sweeps of adder_bist_ctrl against faulty adder models
module tb_adder_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start1, start2;
    logic [4:0] result1, result2;
    logic [3:0] op_a1, op_b1, op_a2, op_b2;
    logic       busy1, done1, pass1, busy2, done2, pass2;
    logic [8:0] err1, err2;
    logic [3:0] fa1, fb1, fa2, fb2;
    logic [4:0] fr1, fr2;

    logic [4:0] m0, m1;
    logic       fast2;
    logic [4:0] r1, s1, s2;

    always @(posedge clk) r1 <= (({1'b0, op_a1} + {1'b0, op_b1}) & ~m0) | m1;
    always @(posedge clk) begin
        s1 <= {1'b0, op_a2} + {1'b0, op_b2};
        s2 <= s1;
    end
    assign result1 = r1;
    assign result2 = fast2 ? s1 : s2;

    adder_bist_ctrl #(.WIDTH(4), .LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .result(result1),
        .op_a(op_a1), .op_b(op_b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_a(fa1), .fail_b(fb1), .fail_res(fr1)
    );

    adder_bist_ctrl #(.WIDTH(4), .LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .result(result2),
        .op_a(op_a2), .op_b(op_b2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_a(fa2), .fail_b(fb2), .fail_res(fr2)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: for every vector k, the checker sees the adder's answer for vector
    // min(k+skew, last), where skew = checker latency - adder latency.
    function automatic void ref_sweep(input int skew, input int z0, input int z1,
                                      output int errs, output int ra, output int rb, output int rr);
        errs = 0; ra = 0; rb = 0; rr = 0;
        for (int k = 0; k < 256; k++) begin
            int s, obs;
            s   = (k + skew > 255) ? 255 : k + skew;
            obs = (((s / 16) + (s % 16)) & ~z0) | z1;
            if (obs != (k / 16) + (k % 16)) begin
                if (errs == 0) begin
                    ra = k / 16; rb = k % 16; rr = obs;
                end
                errs++;
            end
        end
    endfunction

    task automatic sweep1(output int len);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("s1_busy_after_e0", busy1, 1);
        chk("s1_vec0", {op_a1, op_b1}, 0);
        len = 0;
        while (!done1 && len < 400) begin
            @(posedge clk); #1;
            len++;
        end
    endtask

    task automatic sweep2(output int len);
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        chk("s2_busy_after_e0", busy2, 1);
        len = 0;
        while (!done2 && len < 400) begin
            @(posedge clk); #1;
            len++;
        end
    endtask

    task automatic verify1(input string tag, input int z0, input int z1);
        int e, ra, rb, rr;
        ref_sweep(0, z0, z1, e, ra, rb, rr);
        chk({tag, "_err"}, err1, e);
        chk({tag, "_pass"}, pass1, (e == 0) ? 1 : 0);
        chk({tag, "_fa"}, fa1, ra);
        chk({tag, "_fb"}, fb1, rb);
        chk({tag, "_fr"}, fr1, rr);
    endtask

    initial begin
        int len, seen, back, e, ra, rb, rr;
        logic [7:0] prev;
        rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0;
        m0 = '0; m1 = '0; fast2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_pass", pass1, 0);
        chk("rst_err", err1, 0);
        chk("rst_ops", {op_a1, op_b1}, 0);
        chk("rst_fail", {fa1, fb1, fr1}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ideal adder
        sweep1(len);
        chk("ideal_len", len, 257);
        chk("ideal_busy", busy1, 0);
        chk("ideal_last_vec", {op_a1, op_b1}, 8'hFF);
        chk("ideal_last_res", result1, 5'h1E);
        verify1("ideal", 0, 0);

        // sum bit 0 stuck at 0
        m0 = 5'h01;
        sweep1(len);
        chk("sa0_len", len, 257);
        chk("sa0_err", err1, 128);
        chk("sa0_fa", fa1, 0);
        chk("sa0_fb", fb1, 1);
        chk("sa0_fr", fr1, 0);
        chk("sa0_pass", pass1, 0);

        // carry out stuck at 0
        m0 = 5'h10;
        sweep1(len);
        chk("cout_err", err1, 120);
        chk("cout_fa", fa1, 1);
        chk("cout_fb", fb1, 15);
        chk("cout_fr", fr1, 0);
        chk("cout_pass", pass1, 0);

        // random stuck-at patterns
        for (int i = 0; i < 4; i++) begin
            m0 = 5'($urandom);
            m1 = 5'($urandom) & ~m0;
            if (i == 0) m1 = '0;
            sweep1(len);
            chk("rnd_len", len, 257);
            verify1("rnd", int'(m0), int'(m1));
        end
        m0 = '0; m1 = '0;

        // LAT=2 checker against a 1-edge adder, then a 2-edge adder
        fast2 = 1'b1;
        sweep2(len);
        ref_sweep(1, 0, 0, e, ra, rb, rr);
        chk("lat_mis_len", len, 258);
        chk("lat_mis_err", err2, e);
        chk("lat_mis_pass", pass2, 0);
        chk("lat_mis_fa", fa2, ra);
        chk("lat_mis_fb", fb2, rb);
        chk("lat_mis_fr", fr2, rr);
        fast2 = 1'b0;
        sweep2(len);
        chk("lat2_len", len, 258);
        chk("lat2_pass", pass2, 1);
        chk("lat2_err", err2, 0);

        // reset mid-sweep
        m0 = 5'h01;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy1, 0);
        chk("abort_err", err1, 0);
        chk("abort_ops", {op_a1, op_b1}, 0);
        chk("abort_fail", {fa1, fb1, fr1}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m0 = '0;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (done1 || busy1) seen++;
        end
        chk("abort_no_done", seen, 0);
        sweep1(len);
        chk("resweep_len", len, 257);
        chk("resweep_pass", pass1, 1);

        // start held high throughout
        start1 = 1'b1;
        @(posedge clk); #1;
        len = 0; back = 0; prev = {op_a1, op_b1};
        while (!done1 && len < 400) begin
            @(posedge clk); #1;
            len++;
            if ({op_a1, op_b1} < prev) back++;
            prev = {op_a1, op_b1};
        end
        chk("held_len", len, 257);
        chk("held_no_restart", back, 0);
        chk("held_pass", pass1, 1);
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("b2b_done_drop", done1, 0);
        chk("b2b_busy", busy1, 1);
        chk("b2b_vec0", {op_a1, op_b1}, 0);
        chk("b2b_pass_clr", pass1, 0);
        len = 0;
        while (!done1 && len < 400) begin
            @(posedge clk); #1;
            len++;
        end
        chk("b2b_len", len, 257);
        chk("b2b_pass", pass1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
